// File: rtl/crc_tx_arbiter_if.sv
// Parallel-side handshake and serial-line bundle of the CRC-4 transmit arbiter.
// Requesters drive the master side; the arbiter owns the slave side.
interface crc_tx_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              i_req0;
  logic              i_req1;
  logic [DATA_W-1:0] i_data0;
  logic [DATA_W-1:0] i_data1;
  logic              o_ack0;
  logic              o_ack1;
  logic              o_bit;
  logic              o_bit_valid;
  logic              o_crc_flag;
  logic              o_frame_done;
  logic              o_owner;
  logic              o_busy;

  modport master (
    output i_req0, i_req1, i_data0, i_data1,
    input  o_ack0, o_ack1, o_bit, o_bit_valid, o_crc_flag, o_frame_done, o_owner, o_busy
  );

  modport slave (
    input  i_req0, i_req1, i_data0, i_data1,
    output o_ack0, o_ack1, o_bit, o_bit_valid, o_crc_flag, o_frame_done, o_owner, o_busy
  );
endinterface

// File: rtl/crc_tx_arbiter.sv
// Round-robin two-requester scheduler that serialises the granted word MSB-first
// followed by its CRC-4; every output is registered.
module crc_tx_arbiter #(
  parameter int         DATA_W = 8,
  parameter logic [4:0] GPE    = 5'b10111
) (
  input  logic            i_clk,
  input  logic            i_reset,
  crc_tx_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 4);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_CRC  = CNT_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
    logic fb;
    fb = crc[3] ^ din;
    if (fb) begin
      return {crc[2:0], 1'b0} ^ GPE[3:0];
    end else begin
      return {crc[2:0], 1'b0};
    end
  endfunction

  state_t            state_r, state_nx_s;
  logic [DATA_W-1:0] shift_r, shift_nx_s;
  logic [3:0]        crc_r, crc_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
  logic              ptr_r, ptr_nx_s;
  logic              grant_s, gnt_id_s;
  logic [DATA_W-1:0] sel_data_s;

  logic ack0_r, ack1_r, bit_r, valid_r, flag_r, done_r, owner_r, busy_r;
  logic ack0_nx_s, ack1_nx_s, bit_nx_s, valid_nx_s, flag_nx_s, done_nx_s, owner_nx_s, busy_nx_s;

  // ptr_r names the requester served last; on a tie the other one wins
  assign grant_s    = bus.i_req0 | bus.i_req1;
  assign gnt_id_s   = (bus.i_req0 & bus.i_req1) ? ~ptr_r : bus.i_req1;
  assign sel_data_s = gnt_id_s ? bus.i_data1 : bus.i_data0;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode: the counter marks the last cycle of DATA and CRC
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (grant_s) state_nx_s = ST_DATA; else state_nx_s = ST_IDLE;
      ST_DATA: if (cnt_r == CNT_ZERO) state_nx_s = ST_CRC; else state_nx_s = ST_DATA;
      ST_CRC:  if (cnt_r == CNT_ZERO) state_nx_s = ST_IDLE; else state_nx_s = ST_CRC;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output and datapath decode; the grant edge already presents the payload MSB
  always_comb begin
    ack0_nx_s  = 1'b0;
    ack1_nx_s  = 1'b0;
    bit_nx_s   = 1'b0;
    valid_nx_s = 1'b0;
    flag_nx_s  = 1'b0;
    done_nx_s  = 1'b0;
    owner_nx_s = 1'b0;
    shift_nx_s = shift_r;
    crc_nx_s   = crc_r;
    cnt_nx_s   = cnt_r;
    ptr_nx_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          ack0_nx_s  = ~gnt_id_s;
          ack1_nx_s  = gnt_id_s;
          bit_nx_s   = sel_data_s[DATA_W-1];
          valid_nx_s = 1'b1;
          owner_nx_s = gnt_id_s;
          shift_nx_s = {sel_data_s[DATA_W-2:0], 1'b0};
          crc_nx_s   = crc4_step(4'b0000, sel_data_s[DATA_W-1]);
          cnt_nx_s   = CNT_DATA;
          ptr_nx_s   = gnt_id_s;
        end else begin
          cnt_nx_s = CNT_ZERO;
        end
      end
      ST_DATA: begin
        valid_nx_s = 1'b1;
        owner_nx_s = owner_r;
        if (cnt_r == CNT_ZERO) begin
          bit_nx_s  = crc_r[3];
          flag_nx_s = 1'b1;
          crc_nx_s  = {crc_r[2:0], 1'b0};
          cnt_nx_s  = CNT_CRC;
        end else begin
          bit_nx_s   = shift_r[DATA_W-1];
          crc_nx_s   = crc4_step(crc_r, shift_r[DATA_W-1]);
          shift_nx_s = {shift_r[DATA_W-2:0], 1'b0};
          cnt_nx_s   = cnt_r - CNT_ONE;
        end
      end
      ST_CRC: begin
        if (cnt_r == CNT_ZERO) begin
          cnt_nx_s = CNT_ZERO;
        end else begin
          valid_nx_s = 1'b1;
          flag_nx_s  = 1'b1;
          owner_nx_s = owner_r;
          bit_nx_s   = crc_r[3];
          crc_nx_s   = {crc_r[2:0], 1'b0};
          cnt_nx_s   = cnt_r - CNT_ONE;
          done_nx_s  = (cnt_r == CNT_ONE);
        end
      end
      default: cnt_nx_s = CNT_ZERO;
    endcase
    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  // Datapath and output registers; an aborted frame leaves nothing behind
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_r <= '0;
      crc_r   <= 4'b0000;
      cnt_r   <= CNT_ZERO;
      ptr_r   <= 1'b1;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      bit_r   <= 1'b0;
      valid_r <= 1'b0;
      flag_r  <= 1'b0;
      done_r  <= 1'b0;
      owner_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      shift_r <= shift_nx_s;
      crc_r   <= crc_nx_s;
      cnt_r   <= cnt_nx_s;
      ptr_r   <= ptr_nx_s;
      ack0_r  <= ack0_nx_s;
      ack1_r  <= ack1_nx_s;
      bit_r   <= bit_nx_s;
      valid_r <= valid_nx_s;
      flag_r  <= flag_nx_s;
      done_r  <= done_nx_s;
      owner_r <= owner_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  assign bus.o_ack0       = ack0_r;
  assign bus.o_ack1       = ack1_r;
  assign bus.o_bit        = bit_r;
  assign bus.o_bit_valid  = valid_r;
  assign bus.o_crc_flag   = flag_r;
  assign bus.o_frame_done = done_r;
  assign bus.o_owner      = owner_r;
  assign bus.o_busy       = busy_r;

endmodule

// File: tb/tb_crc_tx_arbiter.sv
// Randomised self-checking bench for crc_tx_arbiter at DATA_W=8 and DATA_W=4,
// checked against a polynomial-division CRC model and a round-robin model.
module tb_crc_tx_arbiter;

  logic clk;
  logic rst;
  int checks   = 0;
  int failures = 0;

  crc_tx_arbiter_if #(.DATA_W(8)) bus8();
  crc_tx_arbiter_if #(.DATA_W(4)) bus4();

  crc_tx_arbiter #(.DATA_W(8), .GPE(5'b10111)) dut8 (.i_clk(clk), .i_reset(rst), .bus(bus8.slave));
  crc_tx_arbiter #(.DATA_W(4), .GPE(5'b10111)) dut4 (.i_clk(clk), .i_reset(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of data * x^4 divided by x^4+x^2+x+1
  function automatic logic [3:0] ref_crc(input logic [15:0] data, input int w);
    logic [19:0] v;
    logic [19:0] g;
    v = {4'b0000, data} << 4;
    for (int i = 19; i >= 4; i--) begin
      if (i < w + 4 && v[i]) begin
        g = 20'h00017 << (i - 4);
        v = v ^ g;
      end
    end
    return v[3:0];
  endfunction

  // Serial order: bit k of the result is the k-th bit on the line
  function automatic logic [19:0] stream(input logic [15:0] data, input logic [3:0] crc, input int w);
    logic [19:0] s;
    s = '0;
    for (int i = 0; i < w; i++) s[i] = data[w-1-i];
    for (int i = 0; i < 4; i++) s[w+i] = crc[3-i];
    return s;
  endfunction

  function automatic logic [19:0] span(input int lo, input int n);
    logic [19:0] s;
    s = '0;
    for (int i = lo; i < lo + n; i++) s[i] = 1'b1;
    return s;
  endfunction

  task automatic sample(input bit sel4, output logic [6:0] s);
    if (sel4) s = {bus4.o_bit_valid, bus4.o_bit, bus4.o_crc_flag, bus4.o_frame_done,
                   bus4.o_owner, bus4.o_ack0, bus4.o_ack1};
    else      s = {bus8.o_bit_valid, bus8.o_bit, bus8.o_crc_flag, bus8.o_frame_done,
                   bus8.o_owner, bus8.o_ack0, bus8.o_ack1};
  endtask

  task automatic all_outs(input bit sel4, output logic [7:0] o);
    if (sel4) o = {bus4.o_ack0, bus4.o_ack1, bus4.o_bit, bus4.o_bit_valid, bus4.o_crc_flag,
                   bus4.o_frame_done, bus4.o_owner, bus4.o_busy};
    else      o = {bus8.o_ack0, bus8.o_ack1, bus8.o_bit, bus8.o_bit_valid, bus8.o_crc_flag,
                   bus8.o_frame_done, bus8.o_owner, bus8.o_busy};
  endtask

  // Records one frame window (bounded wait for its first bit); optionally drops req on ack
  task automatic collect(input bit sel4, input int w, input bit drop,
                         output logic [19:0] bits, output logic [19:0] flags, output logic [19:0] dones,
                         output logic [19:0] owners, output logic [19:0] valids,
                         output int gap, output int acks0, output int acks1);
    logic [6:0] s;
    bits = '0; flags = '0; dones = '0; owners = '0; valids = '0;
    gap = 0; acks0 = 0; acks1 = 0;
    @(negedge clk); sample(sel4, s);
    while (!s[6] && gap < 40) begin
      gap++;
      @(negedge clk); sample(sel4, s);
    end
    for (int i = 0; i < w + 4; i++) begin
      if (i > 0) begin
        @(negedge clk); sample(sel4, s);
      end
      valids[i] = s[6]; bits[i] = s[5]; flags[i] = s[4]; dones[i] = s[3]; owners[i] = s[2];
      acks0 += int'(s[1]);
      acks1 += int'(s[0]);
      if (drop && s[1]) begin
        if (sel4) bus4.i_req0 = 1'b0; else bus8.i_req0 = 1'b0;
      end
      if (drop && s[0]) begin
        if (sel4) bus4.i_req1 = 1'b0; else bus8.i_req1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b1;
    bus8.i_req0 = 1'b0; bus8.i_req1 = 1'b0; bus8.i_data0 = 8'h00; bus8.i_data1 = 8'h00;
    bus4.i_req0 = 1'b0; bus4.i_req1 = 1'b0; bus4.i_data0 = 4'h0; bus4.i_data1 = 4'h0;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      all_outs(b[0], o);
      checks++;
      if (o !== 8'h00) begin failures++; $display("FAIL reset_outs bus%0d got=%h exp=00", b, o); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      all_outs(b[0], o);
      checks++;
      if (o !== 8'h00) begin failures++; $display("FAIL idle_outs bus%0d got=%h exp=00", b, o); end
    end
  endtask

  task automatic test_known_payloads();
    logic [7:0]  dat [3] = '{8'hA5, 8'h80, 8'h00};
    bit          req [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0]  crc [3] = '{4'hF, 4'h7, 4'h0};
    logic [19:0] bits, flags, dones, owners, valids;
    int gap, a0, a1;
    for (int k = 0; k < 3; k++) begin
      if (req[k]) begin bus8.i_data1 = dat[k]; bus8.i_req1 = 1'b1; end
      else        begin bus8.i_data0 = dat[k]; bus8.i_req0 = 1'b1; end
      collect(1'b0, 8, 1'b1, bits, flags, dones, owners, valids, gap, a0, a1);
      checks++;
      if (bits !== stream({8'h00, dat[k]}, crc[k], 8)) begin
        failures++; $display("FAIL known_bits k=%0d got=%h exp=%h", k, bits, stream({8'h00, dat[k]}, crc[k], 8));
      end
      checks++;
      if (valids !== span(0, 12)) begin failures++; $display("FAIL known_valid k=%0d got=%h exp=%h", k, valids, span(0, 12)); end
      checks++;
      if (flags !== span(8, 4)) begin failures++; $display("FAIL known_crcflag k=%0d got=%h exp=%h", k, flags, span(8, 4)); end
      checks++;
      if (dones !== span(11, 1)) begin failures++; $display("FAIL known_done k=%0d got=%h exp=%h", k, dones, span(11, 1)); end
      checks++;
      if (owners !== (req[k] ? span(0, 12) : 20'h0)) begin
        failures++; $display("FAIL known_owner k=%0d got=%h exp_owner=%0d", k, owners, req[k]);
      end
      checks++;
      if (a0 !== (req[k] ? 0 : 1) || a1 !== (req[k] ? 1 : 0)) begin
        failures++; $display("FAIL known_ack k=%0d got=%0d/%0d exp_req=%0d", k, a0, a1, req[k]);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [19:0] bits, flags, dones, owners, valids;
    int gap, a0, a1;
    bit r;
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      if (r) begin bus8.i_data1 = d; bus8.i_req1 = 1'b1; end
      else   begin bus8.i_data0 = d; bus8.i_req0 = 1'b1; end
      collect(1'b0, 8, 1'b1, bits, flags, dones, owners, valids, gap, a0, a1);
      checks++;
      if (bits !== stream({8'h00, d}, ref_crc({8'h00, d}, 8), 8)) begin
        failures++; $display("FAIL rand_bits d=%h got=%h exp=%h", d, bits, stream({8'h00, d}, ref_crc({8'h00, d}, 8), 8));
      end
      checks++;
      if (gap !== 1) begin failures++; $display("FAIL rand_gap d=%h got=%0d exp=1", d, gap); end
      checks++;
      if (owners !== (r ? span(0, 12) : 20'h0) || dones !== span(11, 1)) begin
        failures++; $display("FAIL rand_owner_done d=%h owners=%h dones=%h exp_owner=%0d", d, owners, dones, r);
      end
    end
  endtask

  task automatic test_contention();
    logic [19:0] bits, flags, dones, owners, valids;
    int gap, a0, a1;
    logic [7:0] cur [2];
    bit last, win;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cur[0] = 8'($urandom_range(0, 127));
    cur[1] = 8'($urandom_range(128, 255));
    bus8.i_data0 = cur[0]; bus8.i_data1 = cur[1];
    bus8.i_req0 = 1'b1; bus8.i_req1 = 1'b1;
    last = 1'b1;
    for (int f = 0; f < 4; f++) begin
      win = ~last;
      last = win;
      collect(1'b0, 8, 1'b0, bits, flags, dones, owners, valids, gap, a0, a1);
      checks++;
      if (owners !== (win ? span(0, 12) : 20'h0)) begin
        failures++; $display("FAIL cont_owner f=%0d got=%h exp_owner=%0d", f, owners, win);
      end
      checks++;
      if (a0 !== (win ? 0 : 1) || a1 !== (win ? 1 : 0)) begin
        failures++; $display("FAIL cont_ack f=%0d got=%0d/%0d exp_owner=%0d", f, a0, a1, win);
      end
      checks++;
      if (bits !== stream({8'h00, cur[win]}, ref_crc({8'h00, cur[win]}, 8), 8)) begin
        failures++; $display("FAIL cont_bits f=%0d got=%h exp=%h", f, bits, stream({8'h00, cur[win]}, ref_crc({8'h00, cur[win]}, 8), 8));
      end
      if (f > 0) begin
        checks++;
        if (gap !== 1) begin failures++; $display("FAIL cont_gap f=%0d got=%0d exp=1", f, gap); end
      end
      cur[win] = cur[win] ^ 8'h5A ^ 8'(f);
      if (win) bus8.i_data1 = cur[1]; else bus8.i_data0 = cur[0];
    end
    bus8.i_req0 = 1'b0; bus8.i_req1 = 1'b0;
  endtask

  task automatic test_busy_request();
    logic [6:0] s;
    int n, i;
    bit early_ack1, done_seen;
    bus8.i_data0 = 8'($urandom_range(0, 255));
    bus8.i_req0 = 1'b1;
    n = 0;
    @(negedge clk); sample(1'b0, s);
    while (!s[6] && n < 40) begin n++; @(negedge clk); sample(1'b0, s); end
    early_ack1 = 1'b0; done_seen = 1'b0; i = 0;
    while (!done_seen && i < 20) begin
      if (s[1]) bus8.i_req0 = 1'b0;
      if (s[0]) early_ack1 = 1'b1;
      if (i == 3) begin bus8.i_data1 = 8'($urandom_range(0, 255)); bus8.i_req1 = 1'b1; end
      if (s[3]) done_seen = 1'b1;
      else begin @(negedge clk); sample(1'b0, s); i++; end
    end
    checks++;
    if (early_ack1 !== 1'b0 || done_seen !== 1'b1) begin
      failures++; $display("FAIL busy_no_ack early_ack1=%0d done_seen=%0d exp=0/1", early_ack1, done_seen);
    end
    n = 0;
    do begin @(negedge clk); sample(1'b0, s); n++; end while (!s[0] && n < 20);
    checks++;
    if (n !== 2 || s[2] !== 1'b1) begin failures++; $display("FAIL busy_ack1_delay got=%0d owner=%0d exp=2/1", n, s[2]); end
    bus8.i_req1 = 1'b0;
    n = 0;
    while (!s[3] && n < 20) begin @(negedge clk); sample(1'b0, s); n++; end
  endtask

  task automatic test_mid_reset();
    logic [19:0] bits, flags, dones, owners, valids;
    logic [6:0] s;
    logic [7:0] o;
    logic [7:0] db, dc;
    int gap, a0, a1, n;
    bus8.i_data0 = 8'($urandom_range(0, 255));
    bus8.i_req0 = 1'b1;
    n = 0;
    @(negedge clk); sample(1'b0, s);
    while (!s[6] && n < 40) begin n++; @(negedge clk); sample(1'b0, s); end
    bus8.i_req0 = 1'b0;
    repeat (4) @(negedge clk);
    db = 8'($urandom_range(0, 255));
    dc = 8'($urandom_range(0, 255));
    rst = 1'b1;
    bus8.i_data0 = db; bus8.i_data1 = dc;
    bus8.i_req0 = 1'b1; bus8.i_req1 = 1'b1;
    @(negedge clk);
    all_outs(1'b0, o);
    checks++;
    if (o !== 8'h00) begin failures++; $display("FAIL midrst_outs got=%h exp=00", o); end
    rst = 1'b0;
    collect(1'b0, 8, 1'b1, bits, flags, dones, owners, valids, gap, a0, a1);
    checks++;
    if (owners !== 20'h0 || a0 !== 1 || a1 !== 0) begin
      failures++; $display("FAIL midrst_first_owner owners=%h acks=%0d/%0d exp_owner=0", owners, a0, a1);
    end
    checks++;
    if (bits !== stream({8'h00, db}, ref_crc({8'h00, db}, 8), 8) || dones !== span(11, 1)) begin
      failures++; $display("FAIL midrst_bits got=%h dones=%h exp=%h", bits, dones, stream({8'h00, db}, ref_crc({8'h00, db}, 8), 8));
    end
    collect(1'b0, 8, 1'b1, bits, flags, dones, owners, valids, gap, a0, a1);
    checks++;
    if (owners !== span(0, 12) || bits !== stream({8'h00, dc}, ref_crc({8'h00, dc}, 8), 8)) begin
      failures++; $display("FAIL midrst_second owners=%h bits=%h exp_owner=1", owners, bits);
    end
  endtask

  task automatic test_width4();
    logic [19:0] bits, flags, dones, owners, valids;
    int gap, a0, a1;
    logic [3:0] d;
    bit r;
    for (int k = 0; k < 5; k++) begin
      d = (k == 0) ? 4'b1010 : 4'($urandom_range(0, 15));
      r = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (r) begin bus4.i_data1 = d; bus4.i_req1 = 1'b1; end
      else   begin bus4.i_data0 = d; bus4.i_req0 = 1'b1; end
      collect(1'b1, 4, 1'b1, bits, flags, dones, owners, valids, gap, a0, a1);
      checks++;
      if (bits !== stream({12'h000, d}, ref_crc({12'h000, d}, 4), 4)) begin
        failures++; $display("FAIL w4_bits d=%h got=%h exp=%h", d, bits, stream({12'h000, d}, ref_crc({12'h000, d}, 4), 4));
      end
      checks++;
      if (valids !== span(0, 8) || flags !== span(4, 4) || dones !== span(7, 1)) begin
        failures++; $display("FAIL w4_ctrl d=%h valid=%h flag=%h done=%h", d, valids, flags, dones);
      end
      checks++;
      if (owners !== (r ? span(0, 8) : 20'h0)) begin
        failures++; $display("FAIL w4_owner d=%h got=%h exp_owner=%0d", d, owners, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_payloads();
    test_random_frames();
    test_contention();
    test_busy_request();
    test_mid_reset();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
